// File: rtl/risc_toy_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, downstream redirect/stall,
// and the fetch/decode register outputs. master = fetch stage, slave = its environment.
interface risc_toy_fetch_if;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        REDIRECT;
  logic [29:0] REDIRECT_PC;
  logic        STALL;
  logic        FD_VALID;
  logic [31:0] FD_INSTR;
  logic [29:0] FD_PC;
  logic [29:0] FD_PC4;

  modport master (
    output IREQ, IADDR, FD_VALID, FD_INSTR, FD_PC, FD_PC4,
    input  INSTR, REDIRECT, REDIRECT_PC, STALL
  );

  modport slave (
    input  IREQ, IADDR, FD_VALID, FD_INSTR, FD_PC, FD_PC4,
    output INSTR, REDIRECT, REDIRECT_PC, STALL
  );
endinterface

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction fetch: PC, 1-cycle-latency memory request, FD register
// with a 1-entry skid buffer for decode back-pressure, zero-bubble redirect.
module risc_toy_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input logic             CLK,
  input logic             RST,
  risc_toy_fetch_if.master bus
);

  logic        run_q, run_d;
  logic        inflight_q, inflight_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] resp_pc_q, resp_pc_d;
  logic        fd_v_q, fd_v_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [29:0] fd_pc_q, fd_pc_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [29:0] sk_pc_q, sk_pc_d;

  logic        resp_v;
  logic        ireq;
  logic [29:0] iaddr;
  logic        fd_free;

  assign resp_v  = inflight_q;
  assign fd_free = !fd_v_q || !bus.STALL;
  assign iaddr   = bus.REDIRECT ? bus.REDIRECT_PC : pc_q;
  // Withhold a request whenever its response would have nowhere to land next cycle.
  assign ireq    = run_q && (bus.REDIRECT ||
                   ((!sk_v_q || !bus.STALL) && !(bus.STALL && fd_v_q && resp_v)));

  assign bus.IREQ     = ireq;
  assign bus.IADDR    = iaddr;
  assign bus.FD_VALID = fd_v_q;
  assign bus.FD_INSTR = fd_instr_q;
  assign bus.FD_PC    = fd_pc_q;
  assign bus.FD_PC4   = fd_pc_q + 30'd1;

  always_comb begin
    run_d      = 1'b1;
    inflight_d = ireq;
    pc_d       = ireq ? iaddr + 30'd1 : pc_q;
    resp_pc_d  = ireq ? iaddr : resp_pc_q;
    fd_v_d     = fd_v_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    sk_v_d     = sk_v_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;

    if (bus.REDIRECT) begin
      // Any response arriving now belongs to the killed path.
      fd_v_d = 1'b0;
      sk_v_d = 1'b0;
    end else if (fd_free) begin
      sk_v_d = 1'b0;
      if (sk_v_q) begin
        fd_v_d     = 1'b1;
        fd_instr_d = sk_instr_q;
        fd_pc_d    = sk_pc_q;
      end else if (resp_v) begin
        fd_v_d     = 1'b1;
        fd_instr_d = bus.INSTR;
        fd_pc_d    = resp_pc_q;
      end else begin
        fd_v_d = 1'b0;
      end
    end else if (resp_v) begin
      sk_v_d     = 1'b1;
      sk_instr_d = bus.INSTR;
      sk_pc_d    = resp_pc_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      pc_q       <= RESET_PC;
      resp_pc_q  <= 30'h0;
      fd_v_q     <= 1'b0;
      fd_instr_q <= 32'h0;
      fd_pc_q    <= 30'h0;
      sk_v_q     <= 1'b0;
      sk_instr_q <= 32'h0;
      sk_pc_q    <= 30'h0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      fd_v_q     <= fd_v_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      sk_v_q     <= sk_v_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: start-up, stall/skid, redirects, PC wrap, async reset.
module tb_risc_toy_fetch;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  risc_toy_fetch_if bus ();

  risc_toy_fetch #(.RESET_PC(30'h10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data = 0xA000_0000 + word address, one cycle after the request.
  always @(posedge clk)
    bus.INSTR <= bus.IREQ ? 32'hA000_0000 + {2'b00, bus.IADDR} : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the skid/response exclusivity invariant.
  task automatic tick();
    @(negedge clk);
    total++;
    assert (!(dut.sk_v_q && dut.inflight_q))
    else begin
      bad++;
      $error("FAIL sk_resp_overlap observed=%b expected=0", dut.sk_v_q && dut.inflight_q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.STALL       = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 30'h0;

    // Reset state and start-up
    #12;
    chk("rst_ireq", bus.IREQ, 0);
    chk("rst_fdv", bus.FD_VALID, 0);
    chk("rst_fdpc", bus.FD_PC, 0);
    chk("rst_fdinstr", bus.FD_INSTR, 0);
    tick();
    rst = 1'b0;
    #1 chk("start_ireq_low", bus.IREQ, 0);
    tick();  // N1
    chk("start_ireq", bus.IREQ, 1);
    chk("start_iaddr0", bus.IADDR, 30'h10);
    chk("start_fdv0", bus.FD_VALID, 0);
    tick();  // N2
    chk("start_iaddr1", bus.IADDR, 30'h11);
    chk("start_fdv1", bus.FD_VALID, 0);
    tick();  // N3
    chk("start_iaddr2", bus.IADDR, 30'h12);
    chk("s_fdv", bus.FD_VALID, 1);
    chk("s_fdpc10", bus.FD_PC, 30'h10);
    chk("s_instr10", bus.FD_INSTR, 32'hA000_0010);
    chk("s_pc4_10", bus.FD_PC4, 30'h11);
    tick();  // N4
    chk("s_fdpc11", bus.FD_PC, 30'h11);
    chk("s_instr11", bus.FD_INSTR, 32'hA000_0011);
    tick();  // N5
    chk("s_fdpc12", bus.FD_PC, 30'h12);

    // Stall three cycles with one response captured in the skid buffer
    bus.STALL = 1'b1;
    #1 chk("stall_ireq0", bus.IREQ, 0);
    tick();  // N6
    chk("stall_fdpc_a", bus.FD_PC, 30'h12);
    chk("stall_skv", dut.sk_v_q, 1);
    chk("stall_ireq1", bus.IREQ, 0);
    tick();  // N7
    chk("stall_fdpc_b", bus.FD_PC, 30'h12);
    chk("stall_ireq2", bus.IREQ, 0);
    tick();  // N8
    bus.STALL = 1'b0;
    #1;
    chk("rel_fdpc_held", bus.FD_PC, 30'h12);
    chk("rel_fdv", bus.FD_VALID, 1);
    chk("rel_ireq", bus.IREQ, 1);
    chk("rel_iaddr", bus.IADDR, 30'h14);
    tick();  // N9
    chk("rel_fdpc_sk", bus.FD_PC, 30'h13);
    chk("rel_instr_sk", bus.FD_INSTR, 32'hA000_0013);
    tick();  // N10
    chk("rel_fdpc14", bus.FD_PC, 30'h14);
    chk("rel_instr14", bus.FD_INSTR, 32'hA000_0014);
    tick();  // N11
    chk("rel_fdpc15", bus.FD_PC, 30'h15);

    // Redirect while FD valid and a response is in flight
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 30'h200;
    #1;
    chk("rd_iaddr", bus.IADDR, 30'h200);
    chk("rd_ireq", bus.IREQ, 1);
    tick();  // N12
    bus.REDIRECT = 1'b0;
    #1;
    chk("rd_fdv0", bus.FD_VALID, 0);
    chk("rd_iaddr_next", bus.IADDR, 30'h201);
    tick();  // N13
    chk("rd_fdv1", bus.FD_VALID, 1);
    chk("rd_fdpc200", bus.FD_PC, 30'h200);
    chk("rd_instr200", bus.FD_INSTR, 32'hA000_0200);
    tick();  // N14
    chk("rd_fdpc201", bus.FD_PC, 30'h201);

    // Redirect while stalled with the skid buffer full
    bus.STALL = 1'b1;
    tick();  // N15
    chk("rs_skv", dut.sk_v_q, 1);
    chk("rs_fdpc_held", bus.FD_PC, 30'h201);
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 30'h300;
    #1;
    chk("rs_ireq", bus.IREQ, 1);
    chk("rs_iaddr", bus.IADDR, 30'h300);
    tick();  // N16
    bus.REDIRECT = 1'b0;
    #1;
    chk("rs_fdv0", bus.FD_VALID, 0);
    chk("rs_skv0", dut.sk_v_q, 0);
    chk("rs_iaddr_next", bus.IADDR, 30'h301);
    tick();  // N17
    chk("rs_fdv1", bus.FD_VALID, 1);
    chk("rs_fdpc300", bus.FD_PC, 30'h300);
    chk("rs_instr300", bus.FD_INSTR, 32'hA000_0300);
    bus.STALL = 1'b0;
    tick();  // N18
    chk("rs_fdpc301", bus.FD_PC, 30'h301);

    // Redirect to the top word address, PC wraps to zero
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 30'h3FFF_FFFF;
    #1 chk("wr_iaddr_top", bus.IADDR, 30'h3FFF_FFFF);
    tick();  // N19
    bus.REDIRECT = 1'b0;
    #1 chk("wr_iaddr_zero", bus.IADDR, 30'h0);
    tick();  // N20
    chk("wr_fdpc_top", bus.FD_PC, 30'h3FFF_FFFF);
    chk("wr_pc4_zero", bus.FD_PC4, 30'h0);
    chk("wr_instr_top", bus.FD_INSTR, 32'hDFFF_FFFF);
    tick();  // N21
    chk("wr_fdpc0", bus.FD_PC, 30'h0);
    chk("wr_instr0", bus.FD_INSTR, 32'hA000_0000);

    // Asynchronous reset mid-stream, stalled with skid full
    bus.STALL = 1'b1;
    tick();  // N22
    chk("ar_skv_pre", dut.sk_v_q, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_fdv", bus.FD_VALID, 0);
    chk("ar_fdpc", bus.FD_PC, 0);
    chk("ar_fdinstr", bus.FD_INSTR, 0);
    chk("ar_ireq", bus.IREQ, 0);
    chk("ar_skv", dut.sk_v_q, 0);
    tick();  // N23
    rst = 1'b0;
    bus.STALL = 1'b0;
    #1 chk("ar_rel_ireq", bus.IREQ, 0);
    tick();  // N24
    chk("ar_restart_ireq", bus.IREQ, 1);
    chk("ar_restart_iaddr", bus.IADDR, 30'h10);
    chk("ar_restart_fdv", bus.FD_VALID, 0);
    tick();  // N25
    chk("ar_fdv_empty", bus.FD_VALID, 0);
    tick();  // N26
    chk("ar_fdpc10", bus.FD_PC, 30'h10);
    chk("ar_instr10", bus.FD_INSTR, 32'hA000_0010);
    chk("ar_fdv1", bus.FD_VALID, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
